// File: rtl/fpu_issue_pkg.sv
// fpu_issue_pkg: state, register set, reset value, flag indices and opcode helpers for fpu_issue.
package fpu_issue_pkg;
    localparam int Instr_FPU_Total = 13;
    localparam int FPU_FADD = 0;
    localparam int FPU_FSUB = 1;
    localparam int FPU_FMUL = 2;
    localparam int FPU_FDIV = 3;
    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef struct packed {
        state_t                     state;
        logic                       ena;
        logic                       err;
        logic [Instr_FPU_Total-1:0] ivec;
        logic [63:0]                a;
        logic [63:0]                b;
        logic [63:0]                res;
        logic [4:0]                 resp_fflags;
        logic [4:0]                 fflags;
    } regs_t;
    localparam regs_t REGS_RESET = '0;
    function automatic logic is_onehot(input logic [Instr_FPU_Total-1:0] v);
        return $onehot(v);
    endfunction
endpackage

// File: rtl/fpu_issue.sv
// fpu_issue: single-outstanding FPU request issue/response sequencer with sticky flags.
// Define FPU_ISSUE_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES.
module fpu_issue
    import fpu_issue_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAGW = 6
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [Instr_FPU_Total-1:0] i_req_ivec,
    input  logic [63:0]                i_req_a,
    input  logic [63:0]                i_req_b,
    input  logic [TAGW-1:0]            i_req_tag,
    output logic                       o_fpu_ena,
    output logic [Instr_FPU_Total-1:0] o_fpu_ivec,
    output logic [63:0]                o_fpu_a,
    output logic [63:0]                o_fpu_b,
    input  logic [63:0]                i_fpu_res,
    input  logic                       i_fpu_ex_invalidop,
    input  logic                       i_fpu_ex_divbyzero,
    input  logic                       i_fpu_ex_overflow,
    input  logic                       i_fpu_ex_underflow,
    input  logic                       i_fpu_ex_inexact,
    input  logic                       i_fpu_valid,
    output logic                       o_resp_valid,
    input  logic                       i_resp_ready,
    output logic [63:0]                o_resp_res,
    output logic [TAGW-1:0]            o_resp_tag,
    output logic [4:0]                 o_resp_fflags,
    output logic                       o_resp_err,
    output logic [4:0]                 o_fflags,
    input  logic                       i_fflags_clr,
    output logic                       o_busy
);
    regs_t           r;
    logic [TAGW-1:0] tag;
    logic [4:0]      ex;
    logic            cap;
    logic            expire;
    assign ex  = {i_fpu_ex_invalidop, i_fpu_ex_divbyzero, i_fpu_ex_overflow,
                  i_fpu_ex_underflow, i_fpu_ex_inexact};
    assign cap = r.state == WAIT && i_fpu_valid;
`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt;
    // counter sits at zero outside WAIT, so it restarts on every WAIT entry
    always_ff @(posedge i_clk)
        cnt <= (!i_nrst || r.state != WAIT) ? '0 : cnt + CW'(1);
    assign expire = r.state == WAIT && !i_fpu_valid && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r   <= REGS_RESET;
            tag <= '0;
        end else begin
            r.ena    <= 1'b0;
            r.fflags <= (i_fflags_clr ? 5'd0 : r.fflags) | (cap ? ex : 5'd0);
            case (r.state)
                IDLE: if (i_req_valid) begin
                    tag <= i_req_tag;
                    if (is_onehot(i_req_ivec)) begin
                        r.state <= ISSUE;
                        r.ena   <= 1'b1;
                        r.ivec  <= i_req_ivec;
                        r.a     <= i_req_a;
                        r.b     <= i_req_b;
                    end else begin
                        r.state       <= RESP;
                        r.res         <= '0;
                        r.resp_fflags <= '0;
                        r.err         <= 1'b1;
                    end
                end
                ISSUE: r.state <= WAIT;
                WAIT: if (cap) begin
                    r.state       <= RESP;
                    r.res         <= i_fpu_res;
                    r.resp_fflags <= ex;
                    r.err         <= 1'b0;
                end else if (expire) begin
                    r.state       <= RESP;
                    r.res         <= '0;
                    r.resp_fflags <= '0;
                    r.err         <= 1'b1;
                end
                RESP: if (i_resp_ready) r.state <= IDLE;
                default: r.state <= IDLE;
            endcase
        end
    end
    assign o_req_ready   = r.state == IDLE;
    assign o_busy        = r.state != IDLE;
    assign o_resp_valid  = r.state == RESP;
    assign o_fpu_ena     = r.ena;
    assign o_fpu_ivec    = r.ivec;
    assign o_fpu_a       = r.a;
    assign o_fpu_b       = r.b;
    assign o_resp_res    = r.res;
    assign o_resp_tag    = tag;
    assign o_resp_fflags = r.resp_fflags;
    assign o_resp_err    = r.err;
    assign o_fflags      = r.fflags;
endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: directed scoreboard bench for fpu_issue.
module tb_fpu_issue;
    import fpu_issue_pkg::*;
    localparam int TAGW = 6;
    typedef struct packed {
        logic [63:0]     res;
        logic [TAGW-1:0] tag;
        logic [4:0]      fflags;
        logic            err;
    } exp_t;
    localparam logic [Instr_FPU_Total-1:0] V_FADD = Instr_FPU_Total'(1) << FPU_FADD;
    localparam logic [Instr_FPU_Total-1:0] V_FSUB = Instr_FPU_Total'(1) << FPU_FSUB;
    localparam logic [Instr_FPU_Total-1:0] V_FMUL = Instr_FPU_Total'(1) << FPU_FMUL;
    localparam logic [Instr_FPU_Total-1:0] V_FDIV = Instr_FPU_Total'(1) << FPU_FDIV;
    logic                       i_clk = 1'b0;
    logic                       i_nrst = 1'b0;
    logic                       i_req_valid = 1'b0;
    logic                       o_req_ready;
    logic [Instr_FPU_Total-1:0] i_req_ivec = '0;
    logic [63:0]                i_req_a = '0;
    logic [63:0]                i_req_b = '0;
    logic [TAGW-1:0]            i_req_tag = '0;
    logic                       o_fpu_ena;
    logic [Instr_FPU_Total-1:0] o_fpu_ivec;
    logic [63:0]                o_fpu_a;
    logic [63:0]                o_fpu_b;
    logic [63:0]                i_fpu_res = '0;
    logic [4:0]                 fpu_ex = '0;
    logic                       i_fpu_valid = 1'b0;
    logic                       o_resp_valid;
    logic                       i_resp_ready = 1'b0;
    logic [63:0]                o_resp_res;
    logic [TAGW-1:0]            o_resp_tag;
    logic [4:0]                 o_resp_fflags;
    logic                       o_resp_err;
    logic [4:0]                 o_fflags;
    logic                       i_fflags_clr = 1'b0;
    logic                       o_busy;
    exp_t exp_q[$];
    int   passed = 0;
    int   total = 0;
    int   ena_cnt = 0;
    int   ena_base;

    fpu_issue #(.TIMEOUT_CYCLES(8), .TAGW(TAGW)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_ivec(i_req_ivec), .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_tag(i_req_tag),
        .o_fpu_ena(o_fpu_ena), .o_fpu_ivec(o_fpu_ivec), .o_fpu_a(o_fpu_a), .o_fpu_b(o_fpu_b),
        .i_fpu_res(i_fpu_res),
        .i_fpu_ex_invalidop(fpu_ex[4]), .i_fpu_ex_divbyzero(fpu_ex[3]),
        .i_fpu_ex_overflow(fpu_ex[2]), .i_fpu_ex_underflow(fpu_ex[1]),
        .i_fpu_ex_inexact(fpu_ex[0]),
        .i_fpu_valid(i_fpu_valid),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_res(o_resp_res), .o_resp_tag(o_resp_tag),
        .o_resp_fflags(o_resp_fflags), .o_resp_err(o_resp_err),
        .o_fflags(o_fflags), .i_fflags_clr(i_fflags_clr), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) if (o_fpu_ena) ena_cnt++;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", nm, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // returns one cycle after the acceptance edge (ISSUE cycle for a good opcode)
    task automatic issue(input logic [Instr_FPU_Total-1:0] iv, input logic [63:0] a,
                         input logic [63:0] b, input logic [TAGW-1:0] t);
        int n = 0;
        i_req_valid = 1'b1;
        i_req_ivec  = iv;
        i_req_a     = a;
        i_req_b     = b;
        i_req_tag   = t;
        while (!o_req_ready && n < 50) begin
            tick(1);
            n++;
        end
        chk("req_ready_wait", o_req_ready, 1);
        tick(1);
        i_req_valid = 1'b0;
    endtask

    // called in the ISSUE cycle: fpu_valid lands in WAIT cycle number lat
    task automatic reply(input int lat, input logic [63:0] res, input logic [4:0] fl,
                         input logic clr);
        tick(lat + 1);
        i_fpu_valid  = 1'b1;
        i_fpu_res    = res;
        fpu_ex       = fl;
        i_fflags_clr = clr;
        tick(1);
        i_fpu_valid  = 1'b0;
        fpu_ex       = '0;
        i_fflags_clr = 1'b0;
    endtask

    task automatic collect(input string nm);
        exp_t e;
        int n = 0;
        while (!o_resp_valid && n < 200) begin
            tick(1);
            n++;
        end
        chk({nm, "_valid"}, o_resp_valid, 1);
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty", nm);
            $fatal(1);
        end
        e = exp_q.pop_front();
        chk({nm, "_res"}, o_resp_res, e.res);
        chk({nm, "_tag"}, 64'(o_resp_tag), 64'(e.tag));
        chk({nm, "_fflags"}, 64'(o_resp_fflags), 64'(e.fflags));
        chk({nm, "_err"}, o_resp_err, e.err);
        i_resp_ready = 1'b1;
        tick(1);
        i_resp_ready = 1'b0;
        chk({nm, "_idle_ready"}, o_req_ready, 1);
        chk({nm, "_idle_valid"}, o_resp_valid, 0);
    endtask

    initial begin
        tick(3);
        i_nrst = 1'b1;
        chk("rst_ready", o_req_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_fflags", 64'(o_fflags), 0);
        chk("rst_resp_valid", o_resp_valid, 0);
        chk("rst_ena", o_fpu_ena, 0);
        chk("rst_fpu_a", o_fpu_a, 0);
        // FADD, FPU answers in the 4th WAIT cycle after the first
        exp_q.push_back(exp_t'{64'h4008000000000000, 6'd5, 5'd0, 1'b0});
        issue(V_FADD, 64'h3FF0000000000000, 64'h4000000000000000, 6'd5);
        chk("fadd_ena", o_fpu_ena, 1);
        chk("fadd_ivec", 64'(o_fpu_ivec), 64'(V_FADD));
        chk("fadd_a", o_fpu_a, 64'h3FF0000000000000);
        chk("fadd_b", o_fpu_b, 64'h4000000000000000);
        chk("fadd_busy", o_busy, 1);
        chk("fadd_ready", o_req_ready, 0);
        tick(1);
        chk("fadd_ena_pulse", o_fpu_ena, 0);
        chk("fadd_hold_a", o_fpu_a, 64'h3FF0000000000000);
        tick(4);
        chk("fadd_not_yet", o_resp_valid, 0);
        i_fpu_valid = 1'b1;
        i_fpu_res   = 64'h4008000000000000;
        tick(1);
        i_fpu_valid = 1'b0;
        chk("fadd_lat7", o_resp_valid, 1);
        collect("fadd");
        // sticky flag accumulation and clear-with-capture
        exp_q.push_back(exp_t'{64'h7FF0000000000000, 6'd1, 5'b01000, 1'b0});
        issue(V_FDIV, 64'h3FF0000000000000, 64'd0, 6'd1);
        reply(2, 64'h7FF0000000000000, 5'b01000, 1'b0);
        collect("fdiv");
        chk("sticky_dz", 64'(o_fflags), 64'(5'b01000));
        exp_q.push_back(exp_t'{64'h7FE0000000000000, 6'd2, 5'b00100, 1'b0});
        issue(V_FMUL, 64'h7FE0000000000000, 64'h4000000000000000, 6'd2);
        reply(1, 64'h7FE0000000000000, 5'b00100, 1'b0);
        collect("fmul");
        chk("sticky_dz_of", 64'(o_fflags), 64'(5'b01100));
        exp_q.push_back(exp_t'{64'h7FE0000000000001, 6'd3, 5'b00100, 1'b0});
        issue(V_FMUL, 64'h7FE0000000000001, 64'h4000000000000000, 6'd3);
        reply(0, 64'h7FE0000000000001, 5'b00100, 1'b1);
        chk("sticky_clr_cap", 64'(o_fflags), 64'(5'b00100));
        collect("fmul_clr");
        // bad opcodes never start the FPU
        ena_base = ena_cnt;
        exp_q.push_back(exp_t'{64'd0, 6'd7, 5'd0, 1'b1});
        issue('0, 64'h1, 64'h2, 6'd7);
        chk("bad0_ena", o_fpu_ena, 0);
        collect("bad_zero");
        exp_q.push_back(exp_t'{64'd0, 6'd8, 5'd0, 1'b1});
        issue(V_FADD | V_FMUL, 64'h3, 64'h4, 6'd8);
        collect("bad_two");
        chk("bad_ena_count", 64'(ena_cnt - ena_base), 0);
        chk("bad_sticky", 64'(o_fflags), 64'(5'b00100));
        // back-pressure in RESP; queued request waits for the handshake
        exp_q.push_back(exp_t'{64'h1111, 6'd10, 5'b00001, 1'b0});
        issue(V_FSUB, 64'h5, 64'h6, 6'd10);
        reply(1, 64'h1111, 5'b00001, 1'b0);
        i_req_valid = 1'b1;
        i_req_ivec  = V_FMUL;
        i_req_a     = 64'h77;
        i_req_b     = 64'h88;
        i_req_tag   = 6'd11;
        for (int k = 0; k < 10; k++) begin
            chk("hold_valid", o_resp_valid, 1);
            chk("hold_res", o_resp_res, exp_q[0].res);
            chk("hold_tag", 64'(o_resp_tag), 64'(exp_q[0].tag));
            chk("hold_ready", o_req_ready, 0);
            tick(1);
        end
        collect("hold");
        exp_q.push_back(exp_t'{64'h2222, 6'd11, 5'd0, 1'b0});
        chk("post_hs_busy", o_busy, 0);
        tick(1);
        i_req_valid = 1'b0;
        chk("post_hs_ena", o_fpu_ena, 1);
        chk("post_hs_a", o_fpu_a, 64'h77);
        reply(0, 64'h2222, 5'd0, 1'b0);
        collect("post_hs");
        chk("sticky_nx", 64'(o_fflags), 64'(5'b00101));
`ifdef FPU_ISSUE_TIMEOUT_EN
        exp_q.push_back(exp_t'{64'd0, 6'd12, 5'd0, 1'b1});
        issue(V_FADD, 64'h9, 64'hA, 6'd12);
        tick(8);
        chk("to_early", o_resp_valid, 0);
        tick(1);
        chk("to_resp", o_resp_valid, 1);
        collect("timeout");
        i_fpu_valid = 1'b1;
        fpu_ex      = 5'h1F;
        tick(1);
        i_fpu_valid = 1'b0;
        fpu_ex      = '0;
        chk("late_fflags", 64'(o_fflags), 64'(5'b00101));
        chk("late_busy", o_busy, 0);
        chk("late_resp", o_resp_valid, 0);
`else
        exp_q.push_back(exp_t'{64'h3333, 6'd12, 5'd0, 1'b0});
        issue(V_FADD, 64'h9, 64'hA, 6'd12);
        tick(100);
        chk("nto_busy", o_busy, 1);
        chk("nto_resp", o_resp_valid, 0);
        chk("nto_ready", o_req_ready, 0);
        i_fpu_valid = 1'b1;
        i_fpu_res   = 64'h3333;
        tick(1);
        i_fpu_valid = 1'b0;
        collect("nto");
`endif
        // reset during WAIT abandons the operation
        issue(V_FDIV, 64'hAB, 64'hCD, 6'd13);
        tick(1);
        i_nrst = 1'b0;
        tick(1);
        i_nrst = 1'b1;
        chk("mid_rst_ready", o_req_ready, 1);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_fflags", 64'(o_fflags), 0);
        chk("mid_rst_resp", o_resp_valid, 0);
        chk("mid_rst_fpu_a", o_fpu_a, 0);
        i_fpu_valid = 1'b1;
        i_fpu_res   = 64'hDEAD;
        fpu_ex      = 5'h1F;
        tick(1);
        i_fpu_valid = 1'b0;
        fpu_ex      = '0;
        tick(2);
        chk("stale_fflags", 64'(o_fflags), 0);
        chk("stale_resp", o_resp_valid, 0);
        chk("stale_busy", o_busy, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fpu_issue.md
FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, WAIT-state watchdog limit in cycles (used only with FPU_ISSUE_TIMEOUT_EN).
REQ-002 SHALL have parameter TAGW, default 6, width of the request/response tag (destination register index).
REQ-003 i_clk  in  1  CPU clock; single clock domain.
REQ-004 i_nrst  in  1  reset, synchronous, active-low.
REQ-005 i_req_valid  in  1  pipeline FPU request valid.
REQ-006 o_req_ready  out  1  request accepted when high together with i_req_valid.
REQ-007 i_req_ivec  in  river_cfg_pkg::Instr_FPU_Total  one-hot FPU opcode vector.
REQ-008 i_req_a / i_req_b  in  64 each  operands.
REQ-009 i_req_tag  in  TAGW  request tag.
REQ-010 o_fpu_ena  out  1  FPU start pulse.
REQ-011 o_fpu_ivec  out  Instr_FPU_Total  opcode vector to the FPU.
REQ-012 o_fpu_a / o_fpu_b  out  64 each  operands to the FPU.
REQ-013 i_fpu_res  in  64  FPU result.
REQ-014 i_fpu_ex_invalidop, i_fpu_ex_divbyzero, i_fpu_ex_overflow, i_fpu_ex_underflow, i_fpu_ex_inexact  in  1 each  FPU exception flags.
REQ-015 i_fpu_valid  in  1  FPU result valid, one-cycle pulse.
REQ-016 o_resp_valid  out  1  response valid.
REQ-017 i_resp_ready  in  1  response consumed when high with o_resp_valid.
REQ-018 o_resp_res  out  64  response data.
REQ-019 o_resp_tag  out  TAGW  tag of the originating request.
REQ-020 o_resp_fflags  out  5  flags of this operation: bit4 NV, 3 DZ, 2 OF, 1 UF, 0 NX.
REQ-021 o_resp_err  out  1  bad opcode or timeout.
REQ-022 o_fflags  out  5  sticky accumulated flags, same bit order.
REQ-023 i_fflags_clr  in  1  clears sticky flags.
REQ-024 o_busy  out  1  high in every state except IDLE.

Function
REQ-025 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-026 o_req_ready SHALL be 1 only in IDLE; at most one operation is outstanding.
REQ-027 On acceptance with exactly one ivec bit set: latch ivec, a, b and tag; go to ISSUE.
REQ-028 On acceptance with zero or more than one ivec bit set: go directly to RESP with res=0, fflags=0, err=1; the FPU is not started.
REQ-029 In ISSUE, o_fpu_ena SHALL be 1 for exactly one cycle; next state is WAIT.
REQ-030 o_fpu_ivec/a/b SHALL hold the latched values from ISSUE until the response completes.
REQ-031 In WAIT, i_fpu_valid=1 SHALL capture the result and the five flags, set err=0, and go to RESP on the next cycle.
REQ-032 Minimum latency SHALL be 3 cycles from acceptance to o_resp_valid, plus the FPU latency.
REQ-033 In RESP, o_resp_* SHALL be held stable until i_resp_ready=1, then the block returns to IDLE; the next acceptance is one cycle later.
REQ-034 i_fpu_valid outside WAIT SHALL be ignored.
REQ-035 Sticky update SHALL be fflags_next = (i_fflags_clr ? 0 : fflags) | captured_flags, with capture in the same cycle as i_fpu_valid in WAIT; a simultaneous clear and capture leaves only the new flags.

Reset
REQ-036 While i_nrst=0 at a clock edge: state SHALL be IDLE; all registered outputs, latched operands, tag and sticky flags SHALL be 0.
REQ-037 Reset mid-operation SHALL abandon the operation with no response; a late i_fpu_valid afterwards is ignored.
REQ-038 o_req_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-039 With FPU_ISSUE_TIMEOUT_EN defined: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES-1 without i_fpu_valid, the block goes to RESP with res=0, fflags=0, err=1.
REQ-040 Without FPU_ISSUE_TIMEOUT_EN: no counter exists, WAIT is left only on i_fpu_valid, and err is raised only by REQ-028.

Structure
REQ-041 Package fpu_issue_pkg SHALL hold the state enum, the registers struct, its reset constant and the FFLAG bit-index constants.
REQ-042 No sub-module is required; the one-hot check SHALL be an inline function in the package.

Verification
REQ-043 FADD request, a=0x3FF0000000000000, b=0x4000000000000000, tag=5, FPU returns 0x4008000000000000 after 4 cycles -> resp res=0x4008000000000000, tag=5, fflags=0, err=0, 7 cycles after acceptance.
REQ-044 FDIV with the FPU returning divbyzero=1 and res 0x7FF0000000000000, then FMUL returning overflow -> o_fflags=5'b01100; assert i_fflags_clr in the cycle the second flags are captured -> o_fflags=5'b00100.
REQ-045 ivec=0, then ivec with two bits set -> o_fpu_ena never asserted; resp err=1, res=0 for both.
REQ-046 Hold i_resp_ready=0 for 10 cycles in RESP -> outputs stable, o_req_ready=0 throughout; a new i_req_valid is not accepted until the cycle after the handshake.
REQ-047 With FPU_ISSUE_TIMEOUT_EN and TIMEOUT_CYCLES=8, FPU never responds -> err=1 at the expected cycle; a late i_fpu_valid in IDLE is ignored. Without the macro, the block is still in WAIT after 100 cycles.
REQ-048 Assert i_nrst=0 during WAIT -> IDLE, o_fflags=0, no response; a stale i_fpu_valid is ignored.
